// File: rtl/regfile_sb.sv
// 32-entry architectural register file with same-cycle write forwarding and a
// per-register busy scoreboard used by decode to stall on RAW hazards.
module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  busy_A,
    output logic                  busy_B,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int CNT_W    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_reg;
    logic [NUM_REGS-1:0]   busy_next;
    logic [CNT_W-1:0]      busy_count_reg;
    logic [CNT_W-1:0]      busy_count_next;

    logic write_active;
    logic write_hit;
    logic fwd_a;
    logic fwd_b;
    logic issue_rd_busy;
    logic issue_set;
    logic wb_clear;

    // Writes are masked while reset is held so nothing leaks through forwarding.
    assign write_active = ctrl_writeEnable && ctrl_reset_n;
    assign write_hit    = write_active && (ctrl_writeReg != '0);

    assign fwd_a = write_hit && (ctrl_writeReg == ctrl_readRegA);
    assign fwd_b = write_hit && (ctrl_writeReg == ctrl_readRegB);

    assign data_readRegA = fwd_a ? data_writeReg : regs_reg[ctrl_readRegA];
    assign data_readRegB = fwd_b ? data_writeReg : regs_reg[ctrl_readRegB];

    assign busy_A = busy_reg[ctrl_readRegA] && !(write_active && (ctrl_writeReg == ctrl_readRegA));
    assign busy_B = busy_reg[ctrl_readRegB] && !(write_active && (ctrl_writeReg == ctrl_readRegB));

    // A writeback landing this cycle frees the slot, so issue may overlap it.
    assign issue_rd_busy = busy_reg[issue_rd] && !(write_active && (ctrl_writeReg == issue_rd));
    assign issue_ready   = issue_valid && ((issue_rd == '0) || !issue_rd_busy);
    assign issue_set     = issue_ready && (issue_rd != '0) && ctrl_reset_n;
    assign wb_clear      = write_hit && busy_reg[ctrl_writeReg];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            // Entry 0 is never hit because write_hit excludes index 0.
            always_ff @(posedge clock or negedge ctrl_reset_n) begin
                if (!ctrl_reset_n) begin
                    regs_reg[gi] <= '0;
                end else if (write_hit && (ctrl_writeReg == ADDR_WIDTH'(gi))) begin
                    regs_reg[gi] <= data_writeReg;
                end
            end

            assign busy_next[gi] =
                (busy_reg[gi] && !(write_hit && (ctrl_writeReg == ADDR_WIDTH'(gi)))) ||
                (issue_set && (issue_rd == ADDR_WIDTH'(gi)));
        end
    endgenerate

    always_comb begin
        busy_count_next = busy_count_reg;
        if (issue_set && !wb_clear) begin
            busy_count_next = busy_count_reg + CNT_W'(1);
        end else if (!issue_set && wb_clear) begin
            busy_count_next = busy_count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy_reg       <= '0;
            busy_count_reg <= '0;
        end else begin
            busy_reg       <= busy_next;
            busy_count_reg <= busy_count_next;
        end
    end

    assign busy_count = busy_count_reg;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expected values are queued when stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_regfile_sb;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        busy_A;
    logic        busy_B;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [5:0]  busy_count;

    int unsigned n_compared   = 0;
    int unsigned n_mismatched = 0;
    logic [31:0] sb_q [$];
    logic [31:0] exp_v;

    regfile_sb dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .busy_A           (busy_A),
        .busy_B           (busy_B),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_ready      (issue_ready),
        .busy_count       (busy_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        issue_valid      = 1'b0;
        issue_rd         = '0;
    endtask

    task automatic do_reset();
        idle();
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        ctrl_reset_n  = 1'b0;
        step();
        ctrl_reset_n  = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        ctrl_reset_n  = 1'b0;
        ctrl_readRegA = 5'd5;
        ctrl_readRegB = 5'd6;
        issue_valid   = 1'b1;
        issue_rd      = 5'd5;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h1);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL reset_dataA got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL reset_count got %0d want %0d", busy_count, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL reset_ready got %0d want %0d", issue_ready, exp_v); end
        $display("reset: A=%h count=%0d ready=%0d", data_readRegA, busy_count, issue_ready);
        idle();
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd5; data_writeReg = 32'hDEADBEEF;
        step();
        idle();
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd0;
        sb_q.push_back(32'hDEADBEEF); sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL r5_read got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegB !== exp_v) begin n_mismatched++; $display("FAIL r0_read got %h want %h", data_readRegB, exp_v); end
        $display("write r5: A=%h B=%h", data_readRegA, data_readRegB);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd0; data_writeReg = 32'h1234;
        ctrl_readRegA = 5'd0;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL r0_nofwd got %h want %h", data_readRegA, exp_v); end
        step();
        idle();
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL r0_after_write got %h want %h", data_readRegA, exp_v); end
        $display("write r0: A=%h", data_readRegA);
    endtask

    task automatic test_forward();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h11;
        step();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd7; data_writeReg = 32'h22;
        ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
        sb_q.push_back(32'h22); sb_q.push_back(32'h22); sb_q.push_back(32'h22); sb_q.push_back(32'h22);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL fwd_A_pre got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegB !== exp_v) begin n_mismatched++; $display("FAIL fwd_B_pre got %h want %h", data_readRegB, exp_v); end
        step();
        idle();
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL fwd_A_post got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegB !== exp_v) begin n_mismatched++; $display("FAIL fwd_B_post got %h want %h", data_readRegB, exp_v); end
        $display("forward r7: A=%h B=%h", data_readRegA, data_readRegB);
    endtask

    task automatic test_raw();
        issue_valid = 1'b1; issue_rd = 5'd9;
        sb_q.push_back(32'h1);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL raw_issue_ready got %0d want %0d", issue_ready, exp_v); end
        step();
        idle();
        ctrl_readRegA = 5'd9;
        sb_q.push_back(32'h1); sb_q.push_back(32'h1);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL raw_count_set got %0d want %0d", busy_count, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_A) !== exp_v) begin n_mismatched++; $display("FAIL raw_busyA_set got %0d want %0d", busy_A, exp_v); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd9; data_writeReg = 32'h55;
        sb_q.push_back(32'h0); sb_q.push_back(32'h55); sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_A) !== exp_v) begin n_mismatched++; $display("FAIL raw_busyA_wb got %0d want %0d", busy_A, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL raw_data_wb got %h want %h", data_readRegA, exp_v); end
        step();
        idle();
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL raw_count_clr got %0d want %0d", busy_count, exp_v); end
        $display("raw r9: data=%h busy_A=%0d count=%0d", data_readRegA, busy_A, busy_count);
    endtask

    task automatic test_waw();
        issue_valid = 1'b1; issue_rd = 5'd3;
        step();
        issue_valid = 1'b1; issue_rd = 5'd3;
        sb_q.push_back(32'h0); sb_q.push_back(32'h1);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL waw_refuse got %0d want %0d", issue_ready, exp_v); end
        step();
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL waw_count_hold got %0d want %0d", busy_count, exp_v); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h33;
        issue_valid = 1'b1; issue_rd = 5'd3;
        sb_q.push_back(32'h1); sb_q.push_back(32'h1); sb_q.push_back(32'h1);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL overlap_ready got %0d want %0d", issue_ready, exp_v); end
        step();
        idle();
        ctrl_readRegB = 5'd3;
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_B) !== exp_v) begin n_mismatched++; $display("FAIL overlap_busy got %0d want %0d", busy_B, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL overlap_count got %0d want %0d", busy_count, exp_v); end
        $display("waw r3: busy_B=%0d count=%0d", busy_B, busy_count);
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h34;
        step();
        idle();
    endtask

    task automatic test_fill();
        issue_valid = 1'b1; issue_rd = 5'd0;
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd12; data_writeReg = 32'hC;
        sb_q.push_back(32'h1); sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL r0_issue_ready got %0d want %0d", issue_ready, exp_v); end
        step();
        idle();
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL nonbusy_wb_count got %0d want %0d", busy_count, exp_v); end
        for (int i = 1; i < 32; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i);
            sb_q.push_back(32'h1);
            #1;
            exp_v = sb_q.pop_front(); n_compared++;
            if (32'(issue_ready) !== exp_v) begin n_mismatched++; $display("FAIL fill_ready r%0d got %0d want %0d", i, issue_ready, exp_v); end
            step();
        end
        idle();
        sb_q.push_back(32'd31);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL fill_count got %0d want %0d", busy_count, exp_v); end
        $display("fill: count=%0d", busy_count);
    endtask

    task automatic test_reset_mid();
        do_reset();
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'hA5A5;
        step();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd4;
        step();
        issue_valid = 1'b1; issue_rd = 5'd8;
        step();
        idle();
        ctrl_readRegA = 5'd4;
        sb_q.push_back(32'hA5A5); sb_q.push_back(32'd2);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL pre_reset_r4 got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL pre_reset_count got %0d want %0d", busy_count, exp_v); end
        ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd4; data_writeReg = 32'hFFFF;
        #1;
        ctrl_reset_n = 1'b0;
        sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0); sb_q.push_back(32'h0);
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL mid_reset_r4 got %h want %h", data_readRegA, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_A) !== exp_v) begin n_mismatched++; $display("FAIL mid_reset_busyA got %0d want %0d", busy_A, exp_v); end
        exp_v = sb_q.pop_front(); n_compared++;
        if (32'(busy_count) !== exp_v) begin n_mismatched++; $display("FAIL mid_reset_count got %0d want %0d", busy_count, exp_v); end
        step();
        idle();
        ctrl_reset_n = 1'b1;
        #1;
        exp_v = sb_q.pop_front(); n_compared++;
        if (data_readRegA !== exp_v) begin n_mismatched++; $display("FAIL reset_write_ignored got %h want %h", data_readRegA, exp_v); end
        $display("mid reset: A=%h busy_A=%0d count=%0d", data_readRegA, busy_A, busy_count);
    endtask

    initial begin
        ctrl_reset_n  = 1'b0;
        ctrl_readRegA = '0;
        ctrl_readRegB = '0;
        idle();
        test_reset();
        test_write_read();
        test_forward();
        test_raw();
        test_waw();
        test_fill();
        test_reset_mid();
        if (sb_q.size() != 0) begin
            n_compared++; n_mismatched++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
